clock_period_meter: RTL



---
 rtl/clock_meter_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/clock_period_meter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter and its input-sampling helpers.
package clock_meter_pkg;

    typedef enum logic {
        WAIT_EDGE,
        MEASURE
    } meter_state_e;

    localparam int unsigned DEFAULT_CNT_WIDTH = 28;
    localparam int unsigned DEFAULT_TIMEOUT   = 32'd268435455;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clock_in domain and flags its rising/falling edges.
module sync_edge_detect
    import clock_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;

    // Shift chain: bit 0 is the metastability catcher, the top bit is the usable level.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~sig_d_q;
    assign fall  = ~level & sig_d_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a divided clock in clock_in cycles, with lock and timeout status.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 valid_out,
    output logic                 locked_out,
    output logic                 timeout_out
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

    logic rise;
    logic fall;
    logic sig_level_unused;

    meter_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] high_lat_q, high_lat_d;
    logic [CNT_WIDTH-1:0] prev_period_q, prev_period_d;
    logic                 have_prev_q, have_prev_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 locked_q, locked_d;
    logic                 timeout_q, timeout_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_in(clock_in),
        .reset   (reset),
        .sig_in  (sig_in),
        .rise    (rise),
        .fall    (fall),
        .level   (sig_level_unused)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= WAIT_EDGE;
            cnt_q         <= '0;
            high_lat_q    <= '0;
            prev_period_q <= '0;
            have_prev_q   <= 1'b0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_lat_q    <= high_lat_d;
            prev_period_q <= prev_period_d;
            have_prev_q   <= have_prev_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    // The first rise only arms the counter; every later rise closes one measurement.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_lat_d    = high_lat_q;
        prev_period_d = prev_period_q;
        have_prev_d   = have_prev_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_d       = 1'b0;
        locked_d      = locked_q;
        timeout_d     = timeout_q;
        case (state_q)
            WAIT_EDGE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d      = ONE_C;
                    high_lat_d = '0;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d      = cnt_q;
                    high_d        = high_lat_q;
                    valid_d       = 1'b1;
                    cnt_d         = ONE_C;
                    high_lat_d    = '0;
                    prev_period_d = cnt_q;
                    locked_d      = (cnt_q == prev_period_q) && have_prev_q;
                    have_prev_d   = 1'b1;
                    timeout_d     = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    // Stopping at TIMEOUT also keeps cnt from ever wrapping.
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT_EDGE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    if (fall) begin
                        high_lat_d = cnt_q;
                    end
                end
            end
            default: state_d = WAIT_EDGE;
        endcase
    end

    assign period_out  = period_q;
    assign high_out    = high_q;
    assign valid_out   = valid_q;
    assign locked_out  = locked_q;
    assign timeout_out = timeout_q;

endmodule
